mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug loader) arbiter in front of a single-port RAM.
// One transaction at a time: IDLE -> ACCESS -> [WAIT x RD_LAT] -> RESP -> IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  input  logic              dbg_lock,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t              state;
  state_t              state_next;

  logic                last_dbg;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [2:0]          wait_cnt;

  logic                cpu_elig;
  logic                dbg_elig;
  logic                any_elig;
  logic                pick_dbg;
  logic                wait_done;

  // dbg_lock only matters here, so a lock raised mid-transaction cannot cancel it.
  assign cpu_elig  = cpu_req & ~dbg_lock;
  assign dbg_elig  = dbg_req;
  assign any_elig  = cpu_elig | dbg_elig;
  // On a tie the requester not served last wins.
  assign pick_dbg  = dbg_elig & (~cpu_elig | ~last_dbg);
  assign wait_done = (wait_cnt == LAST_CNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (wait_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_dbg  <= 1'b1;
      grant     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            grant     <= pick_dbg;
            lat_we    <= pick_dbg ? dbg_we    : cpu_we;
            lat_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
            lat_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_done) begin
            if (grant) begin
              dbg_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          last_dbg <= grant;
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // RAM drive decodes state and latches only: no path from any req input.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    case (state)
      ACCESS: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_wren  = lat_we;
        mem_rden  = ~lat_we;
      end
      WAIT: begin
        mem_addr = lat_addr;
        mem_rden = 1'b1;
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  assign cpu_ack   = (state == RESP) & ~grant;
  assign dbg_ack   = (state == RESP) &  grant;
  assign cpu_stall = cpu_req & ~cpu_ack;

  a_rw_excl: assert property (@(posedge clock) disable iff (reset) !(mem_wren && mem_rden));
  a_ack_excl: assert property (@(posedge clock) disable iff (reset) !(cpu_ack && dbg_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RD_LAT=1 instance for arbitration/handshake,
// RD_LAT=3 instance for long read latency. RAM models live in the bench.
module tb_mem_arbiter;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    int          cyc;
    int          tag;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_rden, mem_wren, grant;

  logic        c3_req = 1'b0, c3_we = 1'b0;
  logic [8:0]  c3_addr = '0;
  logic [31:0] c3_wdata = '0;
  logic [31:0] c3_rdata, d3_rdata;
  logic        c3_ack, c3_stall, d3_ack;
  logic        d3_req = 1'b0, d3_we = 1'b0, d3_lock = 1'b0;
  logic [8:0]  d3_addr = '0;
  logic [31:0] d3_wdata = '0;
  logic [8:0]  mem3_addr;
  logic [31:0] mem3_wdata, mem3_rdata;
  logic        mem3_rden, mem3_wren, grant3;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    rden_q[$];
  resp_t resp3_q[$];
  int    rden3_q[$];

  logic [31:0] cpu_last = '0;
  logic [31:0] dbg_last = '0;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) u1 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_lock(dbg_lock),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) u3 (
    .clock(clock), .reset(reset),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_rdata(c3_rdata), .cpu_ack(c3_ack), .cpu_stall(c3_stall),
    .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr), .dbg_wdata(d3_wdata),
    .dbg_rdata(d3_rdata), .dbg_ack(d3_ack), .dbg_lock(d3_lock),
    .mem_addr(mem3_addr), .mem_wdata(mem3_wdata), .mem_rden(mem3_rden), .mem_wren(mem3_wren),
    .mem_rdata(mem3_rdata), .grant(grant3)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM models: data appears RD_LAT cycles after rden first rises.
  logic [31:0] ram1 [512];
  logic [31:0] pipe1;
  logic [31:0] ram3 [512];
  logic [31:0] pipe3 [3];

  always @(posedge clock) begin
    if (mem_wren) ram1[mem_addr] <= mem_wdata;
    if (mem_rden) pipe1 <= ram1[mem_addr];
    if (mem3_wren) ram3[mem3_addr] <= mem3_wdata;
    if (mem3_rden) pipe3[0] <= ram3[mem3_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata  = pipe1;
  assign mem3_rdata = pipe3[2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  int run1 = 0;
  always @(negedge clock) begin : mon1
    resp_t e;
    wr_t   w;
    if (cpu_ack || dbg_ack) begin
      check("ack_overlap", 64'(cpu_ack & dbg_ack), 64'd0);
      if (resp_q.size() == 0) begin
        check("unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = resp_q.pop_front();
        check($sformatf("ack_who#%0d", e.tag), 64'(dbg_ack), 64'(e.who));
        check($sformatf("grant#%0d", e.tag), 64'(grant), 64'(e.who));
        check($sformatf("rdata#%0d", e.tag), 64'(e.who ? dbg_rdata : cpu_rdata), 64'(e.rdata));
        check($sformatf("ack_cycle#%0d", e.tag), 64'(cyc), 64'(e.cyc));
      end
    end
    if (mem_wren || mem_rden) check("wren_rden_excl", 64'(mem_wren & mem_rden), 64'd0);
    if (mem_wren) begin
      if (wr_q.size() == 0) begin
        check("unexpected_wren", 64'd1, 64'd0);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(w.addr));
        check("wr_data", 64'(mem_wdata), 64'(w.data));
        check("wr_cycle", 64'(cyc), 64'(w.cyc));
      end
    end
    if (mem_rden) begin
      run1++;
    end else if (run1 > 0) begin
      if (rden_q.size() == 0) check("unexpected_rden", 64'd1, 64'd0);
      else check("rden_len", 64'(run1), 64'(rden_q.pop_front()));
      run1 = 0;
    end
    check("cpu_stall", 64'(cpu_stall), 64'(cpu_req & ~cpu_ack));
  end

  int run3 = 0;
  always @(negedge clock) begin : mon3
    resp_t e;
    if (d3_ack) check("u3_dbg_ack", 64'd1, 64'd0);
    if (c3_ack) begin
      if (resp3_q.size() == 0) begin
        check("u3_unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = resp3_q.pop_front();
        check($sformatf("u3_rdata#%0d", e.tag), 64'(c3_rdata), 64'(e.rdata));
        check($sformatf("u3_ack_cycle#%0d", e.tag), 64'(cyc), 64'(e.cyc));
        check($sformatf("u3_grant#%0d", e.tag), 64'(grant3), 64'd0);
        check($sformatf("u3_stall#%0d", e.tag), 64'(c3_stall), 64'd0);
        check($sformatf("u3_dbg_rdata#%0d", e.tag), 64'(d3_rdata), 64'd0);
      end
    end
    if (mem3_rden) begin
      run3++;
    end else if (run3 > 0) begin
      if (rden3_q.size() == 0) check("u3_unexpected_rden", 64'd1, 64'd0);
      else check("u3_rden_len", 64'(run3), 64'(rden3_q.pop_front()));
      run3 = 0;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_cpu_ack"},   64'(cpu_ack),   64'd0);
    check({tag, "_dbg_ack"},   64'(dbg_ack),   64'd0);
    check({tag, "_mem_rden"},  64'(mem_rden),  64'd0);
    check({tag, "_mem_wren"},  64'(mem_wren),  64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_grant"},     64'(grant),     64'd0);
    check({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'd0);
    check({tag, "_dbg_rdata"}, 64'(dbg_rdata), 64'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_zero("rst");
    reset = 1'b0;
    cpu_last = '0;
    dbg_last = '0;
  endtask

  // One transaction from an idle DUT; scramble alters inputs after the grant.
  task automatic txn(input logic who, input logic we, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] rd, input int tag,
                     input bit scramble);
    int c;
    bit seen;
    @(posedge clock); #1;
    c = cyc;
    if (who) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    if (we) begin
      wr_q.push_back(wr_t'{c + 1, a, d});
    end else begin
      rden_q.push_back(2);
      if (who) dbg_last = rd; else cpu_last = rd;
    end
    resp_q.push_back(resp_t'{who, who ? dbg_last : cpu_last, we ? c + 2 : c + 3, tag});
    if (scramble) begin
      @(posedge clock); #1;
      if (who) begin dbg_addr = ~a; dbg_wdata = ~d; end
      else begin cpu_addr = ~a; cpu_wdata = ~d; end
    end
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      seen = who ? dbg_ack : cpu_ack;
    end
    if (!seen) check($sformatf("timeout#%0d", tag), 64'd0, 64'd1);
    @(posedge clock); #1;
    if (who) dbg_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic txn3(input logic we, input logic [8:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input int tag);
    int c;
    bit seen;
    @(posedge clock); #1;
    c = cyc;
    c3_req = 1'b1; c3_we = we; c3_addr = a; c3_wdata = d;
    resp3_q.push_back(resp_t'{1'b0, rd, we ? c + 2 : c + 5, tag});
    if (!we) rden3_q.push_back(4);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      seen = c3_ack;
    end
    if (!seen) check($sformatf("u3_timeout#%0d", tag), 64'd0, 64'd1);
    @(posedge clock); #1;
    c3_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    for (int i = 0; i < 512; i++) begin
      ram1[i] = '0;
      ram3[i] = '0;
    end
    ram1[16] = 32'h1234_5678;
    ram3[64] = 32'h0BAD_F00D;

    repeat (3) @(posedge clock);
    #1;
    check_zero("por");
    reset = 1'b0;

    txn(1'b0, 1'b1, 9'h0A5, 32'hDEAD_BEEF, 32'h0, 1, 1'b1);
    txn(1'b0, 1'b0, 9'h010, 32'h0, 32'h1234_5678, 2, 1'b0);
    txn(1'b0, 1'b1, 9'h011, 32'hCAFE_F00D, 32'h0, 3, 1'b0);
    txn(1'b1, 1'b1, 9'h020, 32'hA5A5_A5A5, 32'h0, 4, 1'b0);
    txn(1'b1, 1'b0, 9'h020, 32'h0, 32'hA5A5_A5A5, 5, 1'b0);
    txn(1'b1, 1'b0, 9'h0A5, 32'h0, 32'hDEAD_BEEF, 6, 1'b0);
    txn(1'b0, 1'b0, 9'h011, 32'h0, 32'hCAFE_F00D, 7, 1'b0);

    // Both held after reset: CPU, DBG, CPU, DBG.
    reset_pulse();
    @(posedge clock); #1;
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h030; cpu_wdata = 32'h1111_1111;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h031; dbg_wdata = 32'h2222_2222;
    resp_q.push_back(resp_t'{1'b0, 32'h0, c + 2, 10});
    resp_q.push_back(resp_t'{1'b1, 32'h0, c + 5, 11});
    resp_q.push_back(resp_t'{1'b0, 32'h0, c + 8, 12});
    resp_q.push_back(resp_t'{1'b1, 32'h0, c + 11, 13});
    wr_q.push_back(wr_t'{c + 1, 9'h030, 32'h1111_1111});
    wr_q.push_back(wr_t'{c + 4, 9'h031, 32'h2222_2222});
    wr_q.push_back(wr_t'{c + 7, 9'h030, 32'h1111_1111});
    wr_q.push_back(wr_t'{c + 10, 9'h031, 32'h2222_2222});
    n = 0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clock);
      if (cpu_ack || dbg_ack) n++;
    end
    if (n < 4) check("tie_timeout", 64'(n), 64'd4);
    @(posedge clock); #1;
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Lock raised while a CPU write is in flight: it still completes.
    @(posedge clock); #1;
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h050; cpu_wdata = 32'h3333_3333;
    resp_q.push_back(resp_t'{1'b0, 32'h0, c + 2, 20});
    wr_q.push_back(wr_t'{c + 1, 9'h050, 32'h3333_3333});
    @(posedge clock); #1;
    dbg_lock = 1'b1;
    n = 0;
    for (int k = 0; k < 30 && n < 1; k++) begin
      @(negedge clock);
      if (cpu_ack) n++;
    end
    if (n < 1) check("lock_inflight_timeout", 64'(n), 64'd1);
    @(posedge clock); #1;
    cpu_req = 1'b0;

    // Locked: only DBG served; after unlock the CPU wins the next tie.
    @(posedge clock); #1;
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h060; cpu_wdata = 32'h4444_4444;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h061; dbg_wdata = 32'h5555_5555;
    resp_q.push_back(resp_t'{1'b1, 32'h0, c + 2, 21});
    resp_q.push_back(resp_t'{1'b1, 32'h0, c + 5, 22});
    resp_q.push_back(resp_t'{1'b1, 32'h0, c + 8, 23});
    resp_q.push_back(resp_t'{1'b0, 32'h0, c + 11, 24});
    wr_q.push_back(wr_t'{c + 1, 9'h061, 32'h5555_5555});
    wr_q.push_back(wr_t'{c + 4, 9'h061, 32'h5555_5555});
    wr_q.push_back(wr_t'{c + 7, 9'h061, 32'h5555_5555});
    wr_q.push_back(wr_t'{c + 10, 9'h060, 32'h4444_4444});
    n = 0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clock);
      if (cpu_ack || dbg_ack) n++;
    end
    if (n < 3) check("lock_dbg_timeout", 64'(n), 64'd3);
    @(posedge clock); #1;
    dbg_lock = 1'b0;
    n = 0;
    for (int k = 0; k < 30 && n < 1; k++) begin
      @(negedge clock);
      if (cpu_ack || dbg_ack) n++;
    end
    if (n < 1) check("unlock_timeout", 64'(n), 64'd1);
    @(posedge clock); #1;
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Reset during WAIT of a DBG read: abandoned, no ack.
    @(posedge clock); #1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020;
    rden_q.push_back(2);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    dbg_req = 1'b0;
    @(posedge clock); #1;
    check_zero("midrst");
    reset = 1'b0;
    cpu_last = '0;
    dbg_last = '0;
    repeat (4) @(posedge clock);
    txn(1'b1, 1'b0, 9'h0A5, 32'h0, 32'hDEAD_BEEF, 30, 1'b0);

    // RD_LAT=3 instance.
    txn3(1'b0, 9'h040, 32'h0, 32'h0BAD_F00D, 40);
    txn3(1'b1, 9'h041, 32'h7777_7777, 32'h0BAD_F00D, 41);
    txn3(1'b0, 9'h041, 32'h0, 32'h7777_7777, 42);

    repeat (5) @(posedge clock);
    #1;
    check("resp_q_left", 64'(resp_q.size()), 64'd0);
    check("wr_q_left", 64'(wr_q.size()), 64'd0);
    check("rden_q_left", 64'(rden_q.size()), 64'd0);
    check("u3_resp_q_left", 64'(resp3_q.size()), 64'd0);
    check("u3_rden_q_left", 64'(rden3_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
